// File: rtl/bitcount_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bitcount_arbiter
// Brief    : Two-requester round-robin arbiter that sequences an external
//            shift/count datapath to return the population count of an operand.
// Revision : 1.0  initial release
// ============================================================================
module bitcount_arbiter #(
    parameter int SCAN_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic [1:0] gnt,
    output logic       busy,
    output logic [1:0] resp_valid,
    output logic [3:0] resp_count,
    output logic       resp_err,
    input  logic [1:0] resp_ack,
    output logic       dp_clear_result,
    output logic       dp_load_a,
    output logic       dp_right_shift,
    output logic       dp_incr,
    output logic       dp_done,
    output logic [7:0] dp_a_in,
    input  logic [7:0] dp_a_out,
    input  logic [2:0] dp_result
);

    localparam int            CW      = (SCAN_LIMIT < 1) ? 1 : $clog2(SCAN_LIMIT + 1);
    localparam logic [CW-1:0] C_LIMIT = CW'(SCAN_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    logic            r_id;
    logic            r_nz;
    logic            r_err;
    logic            r_rr_ptr;
    logic [CW-1:0]   r_shift_cnt;
    logic [3:0]      r_resp_count;
    logic            r_resp_err;

    state_t          w_state_nxt;
    logic            w_id_nxt;
    logic            w_nz_nxt;
    logic            w_err_nxt;
    logic            w_rr_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [3:0]      w_count_nxt;
    logic            w_rerr_nxt;
    logic            w_win;
    logic [7:0]      w_sel_data;

    logic [1:0]      w_gnt;
    logic            w_busy;
    logic [1:0]      w_resp_valid;
    logic            w_clear;
    logic            w_load;
    logic            w_shift;
    logic            w_incr;
    logic            w_done;
    logic [7:0]      w_a_in;

    // Preferred requester wins only on contention; a lone request always wins.
    assign w_win      = (req == 2'b11) ? r_rr_ptr : req[1];
    assign w_sel_data = w_win ? data1 : data0;

    always_comb begin
        w_state_nxt  = r_state;
        w_id_nxt     = r_id;
        w_nz_nxt     = r_nz;
        w_err_nxt    = r_err;
        w_rr_nxt     = r_rr_ptr;
        w_cnt_nxt    = r_shift_cnt;
        w_count_nxt  = r_resp_count;
        w_rerr_nxt   = r_resp_err;
        w_gnt        = 2'b00;
        w_busy       = 1'b0;
        w_resp_valid = 2'b00;
        w_clear      = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_incr       = 1'b0;
        w_done       = 1'b0;
        w_a_in       = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (req != 2'b00) begin
                    w_gnt       = w_win ? 2'b10 : 2'b01;
                    w_clear     = 1'b1;
                    w_load      = 1'b1;
                    w_a_in      = w_sel_data;
                    w_id_nxt    = w_win;
                    w_nz_nxt    = (w_sel_data != 8'h00);
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_busy = 1'b1;
                if (dp_a_out == 8'h00) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_WAIT;
                end else if (r_shift_cnt == C_LIMIT) begin
                    w_done      = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_shift   = 1'b1;
                    w_incr    = dp_a_out[0];
                    w_cnt_nxt = r_shift_cnt + CW'(1);
                end
            end
            S_WAIT: begin
                w_busy = 1'b1;
                // A full 0xFF operand wraps the 3-bit datapath count back to zero.
                if ((dp_result == 3'd0) && r_nz) begin
                    w_count_nxt = 4'd8;
                end else begin
                    w_count_nxt = {1'b0, dp_result};
                end
                w_rerr_nxt  = r_err;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_busy       = 1'b1;
                w_resp_valid = r_id ? 2'b10 : 2'b01;
                if (resp_ack[r_id]) begin
                    w_rr_nxt    = ~r_id;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_id         <= 1'b0;
            r_nz         <= 1'b0;
            r_err        <= 1'b0;
            r_rr_ptr     <= 1'b0;
            r_shift_cnt  <= '0;
            r_resp_count <= 4'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_id         <= w_id_nxt;
            r_nz         <= w_nz_nxt;
            r_err        <= w_err_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_shift_cnt  <= w_cnt_nxt;
            r_resp_count <= w_count_nxt;
            r_resp_err   <= w_rerr_nxt;
        end
    end

    // Controls are forced low for the whole reset cycle, not only after the edge.
    assign gnt             = reset ? w_gnt        : 2'b00;
    assign busy            = reset ? w_busy       : 1'b0;
    assign resp_valid      = reset ? w_resp_valid : 2'b00;
    assign dp_clear_result = reset ? w_clear      : 1'b0;
    assign dp_load_a       = reset ? w_load       : 1'b0;
    assign dp_right_shift  = reset ? w_shift      : 1'b0;
    assign dp_incr         = reset ? w_incr       : 1'b0;
    assign dp_done         = reset ? w_done       : 1'b0;
    assign dp_a_in         = reset ? w_a_in       : 8'h00;
    assign resp_count      = r_resp_count;
    assign resp_err        = r_resp_err;

endmodule
`default_nettype wire

// File: doc/bitcount_arbiter.md
BITCOUNT_ARBITER -- requirements
Module: bitcount_arbiter

Interface
REQ-001 SHALL have parameter SCAN_LIMIT, default 8: maximum shift cycles per job before the watchdog fires.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port req, input, 2: level request per requester; bit i = requester i.
REQ-005 SHALL have port data0, input, 8: operand of requester 0, sampled on its grant cycle.
REQ-006 SHALL have port data1, input, 8: operand of requester 1, sampled on its grant cycle.
REQ-007 SHALL have port gnt, output, 2: one-hot, one-cycle grant pulse.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port resp_valid, output, 2: one-hot; result held for the granted requester.
REQ-010 SHALL have port resp_count, output, 4: number of ones in the operand, 0..8.
REQ-011 SHALL have port resp_err, output, 1: watchdog fired; qualified by resp_valid.
REQ-012 SHALL have port resp_ack, input, 2: per-requester response acknowledge.
REQ-013 SHALL have ports dp_clear_result, dp_load_a, dp_right_shift, dp_incr, dp_done, output, 1 each: datapath controls.
REQ-014 SHALL have port dp_a_in, output, 8: operand to the datapath A register.
REQ-015 SHALL have port dp_a_out, input, 8: datapath A register contents.
REQ-016 SHALL have port dp_result, input, 3: datapath result register.

Function
REQ-017 SHALL implement states IDLE, SCAN, WAIT and RESP; the datapath controls are combinational from the state, dp_a_out and the shift counter.
REQ-018 In IDLE with req != 0, SHALL grant by round-robin: rr_ptr selects the preferred requester; if only one request is active, that requester wins.
REQ-019 On the grant cycle SHALL pulse gnt[id], assert dp_clear_result and dp_load_a, drive dp_a_in = data[id], latch id, latch nz = (data[id] != 0), clear the shift counter, and go to SCAN.
REQ-020 In SCAN with dp_a_out == 0, SHALL assert dp_done for one cycle and go to WAIT.
REQ-021 In SCAN with dp_a_out != 0 and shift counter < SCAN_LIMIT, SHALL assert dp_right_shift, drive dp_incr = dp_a_out[0], and increment the shift counter.
REQ-022 In SCAN with dp_a_out != 0 and shift counter == SCAN_LIMIT, SHALL assert dp_done, set err, and go to WAIT.
REQ-023 In WAIT, SHALL register resp_count = 8 if dp_result == 0 and nz == 1, else {0, dp_result}; SHALL register resp_err = err; then go to RESP.
- The 8 case is the 3-bit datapath count wrapping on 0xFF.
REQ-024 In RESP, SHALL hold resp_valid[id], resp_count and resp_err stable until resp_ack[id] == 1.
- On ack: set rr_ptr = ~id, clear err, go to IDLE.
- Same-cycle ack is accepted.
REQ-025 SHALL ignore resp_ack bits for the non-granted requester and all resp_ack bits outside RESP.
REQ-026 SHALL not sample req outside IDLE; a req still high on return to IDLE is a new request.
REQ-027 Latency: grant at cycle T; n = index of highest set bit + 1 (0 for an operand of 0); dp_done at T+1+n; resp_valid at T+3+n.
REQ-028 At most one of dp_right_shift, dp_load_a and dp_done SHALL be high in any cycle.

Reset
REQ-029 While reset == 0 at a rising edge, SHALL enter IDLE and set rr_ptr = 0, err = 0, resp_count = 0, resp_err = 0 and the shift counter = 0.
REQ-030 During reset, gnt, resp_valid, busy and all dp_* controls SHALL be 0 and dp_a_in SHALL be 0.
REQ-031 Reset asserted mid-SCAN or mid-RESP SHALL abandon the job without issuing dp_done, with no response issued.

Verification
REQ-032 req=01, data0=0x00 -> gnt=01 at T; dp_done at T+1; resp_valid=01 at T+3 with resp_count=0, resp_err=0.
REQ-033 req=10, data1=0xFF -> 8 shift cycles; resp_valid=10 at T+11 with resp_count=8.
REQ-034 req=11 held, data0=0xA5, data1=0x80, each response acked immediately -> grant order 0, 1, 0; counts 4, 1, 4.
REQ-035 Datapath stub holds dp_a_out=0x01 without shifting -> dp_done after 8 shift cycles; resp_err=1; resp_count = stub result.
REQ-036 resp_valid=01 with resp_ack held 0 for 5 cycles, resp_ack=10 pulsed -> outputs stable; ack=01 -> IDLE the next cycle.
REQ-037 reset=0 asserted 3 cycles into SCAN -> next cycle busy=0, all controls 0; a fresh req=01 is served normally.
